// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared definitions for the multi-port register file: default
//           sizing constants, dump FSM state encoding, index-width helper.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

  // Width of a register index; never less than one bit.
  function automatic int idx_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : regfile_scoreboard
// Purpose : Per-register pending-write (busy) bits. Issue sets, writeback
//           clears, set wins on collision. Reports per-read-port busy with
//           same-cycle writeback forwarding taken into account.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int AW       = idx_width(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_next;
  logic [AW-1:0]       ra;
  logic                wr_hit;

  // Next busy vector: clear on writeback, then set on issue so set wins.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (iss_valid && (iss_rd != '0)) begin
      set_mask[iss_rd] = 1'b1;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        clr_mask[wr_addr[w*AW +: AW]] = 1'b1;
      end
    end
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Per-port busy: a same-cycle writeback to the index hides the busy bit.
  always_comb begin
    rd_busy = '0;
    ra      = '0;
    wr_hit  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra     = rd_addr[p*AW +: AW];
      wr_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
          wr_hit = 1'b1;
        end
      end
      rd_busy[p] = busy[ra] & ~wr_hit & (ra != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Purpose : Multi-port register file with write-through bypass, x0 hardwired
//           to zero, issue-time busy scoreboard and an optional sequential
//           register dump engine.
// Config  : define REGFILE_MP_DUMP_EN to build the dump FSM; otherwise
//           dump_req is ignored and all dump_* outputs are held at 0.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter  int NUM_RD     = 2,
  parameter  int NUM_WR     = 2,
  localparam int AW         = idx_width(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                         hazard,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*AW-1:0]         wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_valid,
  input  logic [AW-1:0]                iss_rd,
  input  logic                         dump_req,
  output logic                         dump_valid,
  output logic [AW-1:0]                dump_idx,
  output logic [DATA_WIDTH-1:0]        dump_data,
  output logic                         dump_done
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [AW-1:0]         ra;
  logic [DATA_WIDTH-1:0] rv;

  // Storage update; ascending port order lets the highest port win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Combinational reads with write-through bypass from the winning port.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*AW +: AW];
      rv = regs[ra];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
          rv = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (ra == '0) begin
        rv = '0;
      end
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rv;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

  assign hazard = |(rd_en & rd_busy);

`ifdef REGFILE_MP_DUMP_EN
  dump_state_t   state;
  dump_state_t   state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_next;

  // Dump FSM state and index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Dump FSM next-state and outputs; dump data is raw storage, no bypass.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_req) begin
          state_next = ST_DUMP;
          cnt_next   = '0;
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_idx   = cnt;
        dump_data  = regs[cnt];
        if (cnt == AW'(NUM_REGS - 1)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        dump_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end
`else
  logic unused_dump_req;
  assign unused_dump_req = dump_req;
  assign dump_valid      = 1'b0;
  assign dump_idx        = '0;
  assign dump_data       = '0;
  assign dump_done       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Purpose : Directed self-checking bench for regfile_mp (bypass, x0, write
//           priority, scoreboard, dump engine or its absence, reset).
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              hazard;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              dump_req;
  logic              dump_valid;
  logic [AW-1:0]     dump_idx;
  logic [DW-1:0]     dump_data;
  logic              dump_done;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .NUM_RD     (NRD),
    .NUM_WR     (NWR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .hazard     (hazard),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  int          compared   = 0;
  int          mismatched = 0;
  string       exp_tag[$];
  logic [63:0] exp_val[$];

  task automatic push(input string tag, input logic [63:0] v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    compared++;
    if (exp_val.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      t = exp_tag.pop_front();
      e = exp_val.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en     = '0;
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    dump_req  = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    set_rd(0, 5'd5);
    push("reset_rd0", 64'h0);
    push("reset_busy", 64'h0);
    push("reset_hazard", 64'h0);
    push("reset_dump_valid", 64'h0);
    push("reset_dump_done", 64'h0);
    @(negedge clk);
    pop_check(rd_data[63:0]);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    pop_check(64'(dump_valid));
    pop_check(64'(dump_done));

    // x5 bypass then storage
    tick(); idle();
    set_wr(0, 5'd5, 64'h1234);
    set_rd(0, 5'd5);
    push("x5_bypass", 64'h1234);
    @(negedge clk);
    pop_check(rd_data[63:0]);
    tick(); idle();
    set_rd(1, 5'd5);
    push("x5_stored", 64'h1234);
    @(negedge clk);
    pop_check(rd_data[127:64]);

    // x0 write discarded, same cycle and next cycle
    tick(); idle();
    set_wr(0, 5'd0, 64'hFFFF);
    set_rd(0, 5'd0);
    push("x0_same_cycle", 64'h0);
    @(negedge clk);
    pop_check(rd_data[63:0]);
    tick(); idle();
    set_rd(1, 5'd0);
    push("x0_stored", 64'h0);
    @(negedge clk);
    pop_check(rd_data[127:64]);

    // Both ports write x7: port 1 wins
    tick(); idle();
    set_wr(0, 5'd7, 64'hA);
    set_wr(1, 5'd7, 64'hB);
    set_rd(0, 5'd7);
    push("x7_bypass_winner", 64'hB);
    @(negedge clk);
    pop_check(rd_data[63:0]);
    tick(); idle();
    set_rd(1, 5'd7);
    push("x7_stored_winner", 64'hB);
    @(negedge clk);
    pop_check(rd_data[127:64]);

    // Scoreboard: issue x3
    tick(); idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    rd_en = 2'b01; set_rd(0, 5'd3);
    push("iss_cycle_busy", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    tick(); idle();
    rd_en = 2'b01; set_rd(0, 5'd3);
    push("x3_busy", 64'h1);
    push("x3_hazard", 64'h1);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    // Writeback x3 hides busy in the same cycle
    tick(); idle();
    rd_en = 2'b01; set_rd(0, 5'd3);
    set_wr(0, 5'd3, 64'h33);
    push("x3_wb_busy", 64'h0);
    push("x3_wb_hazard", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    tick(); idle();
    rd_en = 2'b01; set_rd(0, 5'd3);
    push("x3_cleared_busy", 64'h0);
    push("x3_cleared_hazard", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    // Issue and write x3 together: set wins
    tick(); idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    set_wr(1, 5'd3, 64'h44);
    rd_en = 2'b10; set_rd(1, 5'd3);
    push("x3_coll_busy", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    tick(); idle();
    rd_en = 2'b10; set_rd(1, 5'd3);
    push("x3_setwins_busy", 64'h2);
    push("x3_setwins_hazard", 64'h1);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    // Busy without rd_en raises no hazard
    tick(); idle();
    set_rd(1, 5'd3);
    push("x3_noen_busy", 64'h2);
    push("x3_noen_hazard", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));
    // Issue to x0 never marks busy
    tick(); idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick(); idle();
    rd_en = 2'b11;
    push("x0_iss_busy", 64'h0);
    push("x0_iss_hazard", 64'h0);
    @(negedge clk);
    pop_check(64'(rd_busy));
    pop_check(64'(hazard));

    // Load x1..x31 = 2*index
    for (int i = 1; i < NR; i++) begin
      tick(); idle();
      set_wr(0, AW'(i), 64'(2 * i));
    end
    tick(); idle();
    set_rd(0, 5'd31);
    set_rd(1, 5'd16);
    push("load_x31", 64'd62);
    push("load_x16", 64'd32);
    @(negedge clk);
    pop_check(rd_data[63:0]);
    pop_check(rd_data[127:64]);

`ifdef REGFILE_MP_DUMP_EN
    // Full dump with a second dump_req in the middle
    tick(); idle();
    dump_req = 1'b1;
    push("dump_req_cycle_valid", 64'h0);
    @(negedge clk);
    pop_check(64'(dump_valid));
    for (int k = 0; k < NR; k++) begin
      tick(); idle();
      if (k == 5) dump_req = 1'b1;
      push("dump_valid", 64'h1);
      push("dump_idx", 64'(k));
      push("dump_data", 64'(2 * k));
      push("dump_done_early", 64'h0);
      @(negedge clk);
      pop_check(64'(dump_valid));
      pop_check(64'(dump_idx));
      pop_check(dump_data);
      pop_check(64'(dump_done));
    end
    tick(); idle();
    push("dump_done_pulse", 64'h1);
    push("dump_done_valid", 64'h0);
    @(negedge clk);
    pop_check(64'(dump_done));
    pop_check(64'(dump_valid));
    tick(); idle();
    push("dump_after_done", 64'h0);
    push("dump_after_valid", 64'h0);
    @(negedge clk);
    pop_check(64'(dump_done));
    pop_check(64'(dump_valid));

    // Mark x9 busy, start a dump and reset at index 10
    tick(); idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    dump_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick(); idle();
      if (k == 10) reset = 1'b1;
      push("abort_idx", 64'(k));
      @(negedge clk);
      pop_check(64'(dump_idx));
    end
`else
    // No dump engine: request ignored, outputs stay 0
    tick(); idle();
    dump_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      push("nodump_valid", 64'h0);
      push("nodump_idx", 64'h0);
      push("nodump_data", 64'h0);
      push("nodump_done", 64'h0);
      @(negedge clk);
      pop_check(64'(dump_valid));
      pop_check(64'(dump_idx));
      pop_check(dump_data);
      pop_check(64'(dump_done));
    end
    tick(); idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    reset = 1'b1;
`endif
    tick(); idle();
    reset = 1'b0;
    push("post_reset_valid", 64'h0);
    push("post_reset_idx", 64'h0);
    push("post_reset_done", 64'h0);
    @(negedge clk);
    pop_check(64'(dump_valid));
    pop_check(64'(dump_idx));
    pop_check(64'(dump_done));

    // Every register reads 0 and nothing is busy
    for (int i = 0; i < NR / 2; i++) begin
      tick(); idle();
      rd_en = 2'b11;
      set_rd(0, AW'(2 * i));
      set_rd(1, AW'(2 * i + 1));
      push("clr_rd0", 64'h0);
      push("clr_rd1", 64'h0);
      push("clr_busy", 64'h0);
      push("clr_hazard", 64'h0);
      push("clr_dump_valid", 64'h0);
      push("clr_dump_done", 64'h0);
      @(negedge clk);
      pop_check(rd_data[63:0]);
      pop_check(rd_data[127:64]);
      pop_check(64'(rd_busy));
      pop_check(64'(hazard));
      pop_check(64'(dump_valid));
      pop_check(64'(dump_done));
    end
    // An unaborted dump would pulse done within these cycles
    for (int k = 0; k < 8; k++) begin
      tick(); idle();
      push("abort_no_done", 64'h0);
      @(negedge clk);
      pop_check(64'(dump_done));
    end

    if (exp_val.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_val.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, number of architectural registers (power of two, at least 2); AW = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 The block SHALL have port clk, input, 1 bit, clock; reset, input, 1 bit, synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port rd_en, input, NUM_RD bits, per-port read request, used for hazard qualification only.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*AW bits, per-port read index.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_WIDTH bits, per-port read data.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD bits, per-port pending-write flag.
REQ-010 The block SHALL have port hazard, output, 1 bit, OR over ports of (rd_en & rd_busy).
REQ-011 The block SHALL have ports wr_en (input, NUM_WR bits), wr_addr (input, NUM_WR*AW bits) and wr_data (input, NUM_WR*DATA_WIDTH bits), the writeback ports.
REQ-012 The block SHALL have ports iss_valid (input, 1 bit) and iss_rd (input, AW bits), the issue-time destination reservation.
REQ-013 The block SHALL have ports dump_req (input, 1 bit), dump_valid (output, 1 bit), dump_idx (output, AW bits), dump_data (output, DATA_WIDTH bits) and dump_done (output, 1 bit).

Function
REQ-014 Reads SHALL be combinational; a read of index 0 SHALL always return 0.
REQ-015 A write SHALL take effect at the rising clk edge when its wr_en bit is 1; writes to index 0 SHALL be discarded.
REQ-016 When two or more write ports target the same index in one cycle, the highest-numbered port SHALL win.
REQ-017 Write-through bypass: a read of index N (N != 0) SHALL return the same-cycle wr_data of the winning port writing N, and the stored value otherwise.
REQ-018 Scoreboard: iss_valid with iss_rd != 0 SHALL set busy[iss_rd] at the next edge; any enabled write to N SHALL clear busy[N] at the next edge; if set and clear coincide on the same N, set SHALL win.
REQ-019 rd_busy[p] SHALL equal busy[rd_addr[p]] AND NOT (a same-cycle write to that index); it SHALL be 0 for index 0.
REQ-020 Dump FSM states SHALL be IDLE, DUMP and DONE. IDLE goes to DUMP on dump_req. DUMP emits one register per cycle, dump_idx 0..NUM_REGS-1, with dump_valid=1 and dump_data = stored value without bypass. After index NUM_REGS-1, DUMP goes to DONE. DONE pulses dump_done for exactly 1 cycle, then returns to IDLE.
REQ-021 dump_req SHALL be ignored outside IDLE; register writes and scoreboard updates SHALL continue normally during a dump.
REQ-022 A full dump SHALL take NUM_REGS+1 cycles, from the first dump_valid cycle through the dump_done cycle inclusive.

Reset
REQ-023 On reset, all registers, all busy bits, dump_valid, dump_idx, dump_data and dump_done SHALL be 0, and the FSM SHALL be in IDLE.
REQ-024 Reset asserted mid-dump SHALL abort the dump in the next cycle with no dump_done pulse.
REQ-025 Reset SHALL take priority over same-cycle writes, issues and dump_req.

Configuration
REQ-026 With macro REGFILE_MP_DUMP_EN defined, the dump FSM SHALL be present and behave per REQ-020 to REQ-022.
REQ-027 Without REGFILE_MP_DUMP_EN, the dump FSM SHALL be omitted: dump_req is ignored and all dump_* outputs are tied to 0. Ports SHALL be unchanged in both builds.

Structure
REQ-028 Package regfile_pkg SHALL hold the dump state enum typedef, the default DATA_WIDTH/NUM_REGS constants, and the index-width helper function.
REQ-029 Busy-bit set/clear/priority logic SHALL live in sub-module regfile_scoreboard; the storage, bypass and dump logic SHALL stay in regfile_mp.

Verification
REQ-030 Write x5=0x1234 on port 0 and read x5 in the same cycle -> rd_data=0x1234 via bypass; read again the next cycle -> 0x1234 from storage.
REQ-031 Write x0=0xFFFF, then read x0 -> 0; both ports write x7 in the same cycle (0xA on port 0, 0xB on port 1) -> x7=0xB.
REQ-032 Issue iss_rd=3, then read x3 with rd_en=1 -> rd_busy=1 and hazard=1; write x3 -> hazard=0 in that cycle, busy cleared the next cycle; issue and write x3 in the same cycle -> busy remains 1.
REQ-033 (DUMP_EN build) Load x1..x31 = index*2 and pulse dump_req -> 32 consecutive dump_valid cycles with dump_data=2*dump_idx, then one dump_done cycle; a second dump_req during the dump has no effect.
REQ-034 Assert reset at dump_idx=10 -> dump_valid=0 the next cycle, no dump_done, all registers read 0, all busy bits 0.
